// File: rtl/pio_in_edge_irq.sv
// ---------------------------------------------------------------------------
// pio_in_edge_irq
//
// Avalon-MM slave input PIO. Synchronises an external input bus into clk,
// exposes the live value, latches per-bit edge events into a write-1-to-clear
// capture register and raises a level interrupt when any captured bit that is
// also enabled in the interrupt mask is set.
//
// Register map (word address):
//   0 DATA        : synchronised input value (read only)
//   1 reserved    : reads 0
//   2 IRQMASK     : read/write, WIDTH bits
//   3 EDGECAPTURE : read captured bits, write 1 to clear a bit
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   address    : Avalon word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (bits above WIDTH ignored)
//   in_port    : asynchronous external inputs
//   readdata   : read data, zero read latency, combinational from address
//   irq        : level interrupt, active high
// ---------------------------------------------------------------------------
module pio_in_edge_irq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] ARM_COUNT = CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_irqMask;
    logic [WIDTH-1:0]                  r_edgeCap;
    logic [CNT_W-1:0]                  r_armCount;

    logic [WIDTH-1:0] w_syncOut;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clear;
    logic             w_armed;
    logic             w_wrEn;
    logic             w_wrMask;
    logic             w_wrCap;
    logic             w_unusedWritedata;

    assign w_syncOut = r_sync[SYNC_STAGES-1];
    assign w_armed   = (r_armCount == ARM_COUNT);

    assign w_wrEn    = chipselect & ~write_n;
    assign w_wrMask  = w_wrEn & (address == 2'd2);
    assign w_wrCap   = w_wrEn & (address == 2'd3);

    // Only the low WIDTH bits of writedata matter; fold the rest away.
    assign w_unusedWritedata = ^writedata;

    // Synchroniser chain: stage 0 samples the raw pins, the last stage is the
    // value the rest of the block trusts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    // Previous synchronised value, the reference for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_syncOut;
        end
    end

    // Arm counter. After reset the chain fills with whatever level the pins
    // sit at, which would look like a rising edge for any pin held high.
    // Capture stays disabled until the chain and prev have both settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armCount <= '0;
        end else if (!w_armed) begin
            r_armCount <= r_armCount + CNT_W'(1);
        end
    end

    // Edge vector selected at elaboration time.
    generate
        if (EDGE_TYPE == 0) begin : gRising
            assign w_edge = w_syncOut & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : gFalling
            assign w_edge = ~w_syncOut & r_prev;
        end else begin : gAny
            assign w_edge = w_syncOut ^ r_prev;
        end
    endgenerate

    assign w_set   = w_armed ? w_edge : '0;
    assign w_clear = w_wrCap ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, plain read/write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqMask <= '0;
        end else if (w_wrMask) begin
            r_irqMask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture. A new edge beats a simultaneous clear on the same
    // bit so an event arriving during the CPU's acknowledge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgeCap <= '0;
        end else begin
            r_edgeCap <= w_set | (r_edgeCap & ~w_clear);
        end
    end

    assign irq = |(r_edgeCap & r_irqMask);

    // Read mux: zero wait state, independent of chipselect, no side effects.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[WIDTH-1:0] = w_syncOut;
            2'd1: readdata = '0;
            2'd2: readdata[WIDTH-1:0] = r_irqMask;
            2'd3: readdata[WIDTH-1:0] = r_edgeCap;
        endcase
    end

endmodule
